// File: rtl/stack_proc_core.sv
// Stack-machine execution core: fetch/decode/execute over a sync-read ROM and RAM, with an
// internal operand stack, ALU, branches and overflow/underflow/illegal-opcode trapping.
module stack_proc_core #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RAM_AW      = 5,
  parameter int unsigned ROM_AW      = 5,
  parameter int unsigned STACK_DEPTH = 8,
  localparam int unsigned OPW        = (RAM_AW > ROM_AW) ? RAM_AW : ROM_AW,
  localparam int unsigned SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [OPW+4:0]    i_rom_q,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_wren,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_halted,
  output logic [1:0]        o_trap,
  output logic [ROM_AW-1:0] o_pc,
  output logic [SP_W-1:0]   o_sp,
  output logic [DATA_W-1:0] o_tos
);

  localparam int unsigned IW = OPW + 5;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [4:0] OP_NOP    = 5'h00;
  localparam logic [4:0] OP_PUSH_M = 5'h01;
  localparam logic [4:0] OP_PUSH_I = 5'h02;
  localparam logic [4:0] OP_DUP    = 5'h03;
  localparam logic [4:0] OP_POP_M  = 5'h04;
  localparam logic [4:0] OP_ADD    = 5'h05;
  localparam logic [4:0] OP_SUB    = 5'h06;
  localparam logic [4:0] OP_MUL    = 5'h07;
  localparam logic [4:0] OP_AND    = 5'h08;
  localparam logic [4:0] OP_OR     = 5'h09;
  localparam logic [4:0] OP_XOR    = 5'h0A;
  localparam logic [4:0] OP_NOT    = 5'h0B;
  localparam logic [4:0] OP_GOTO   = 5'h0C;
  localparam logic [4:0] OP_IFEQ   = 5'h0D;
  localparam logic [4:0] OP_IFGT   = 5'h0E;
  localparam logic [4:0] OP_IFLT   = 5'h0F;
  localparam logic [4:0] OP_HALT   = 5'h1F;

  localparam logic [1:0] TRAP_OVF = 2'b01;
  localparam logic [1:0] TRAP_UNF = 2'b10;
  localparam logic [1:0] TRAP_ILL = 2'b11;

  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0] SP_TWO  = SP_W'(2);

  logic [2:0]        r_state;
  logic [ROM_AW-1:0] r_pc;
  logic [IW-1:0]     r_ir;
  logic [SP_W-1:0]   r_sp;
  logic [DATA_W-1:0] r_stack [STACK_DEPTH];
  logic [1:0]        r_trap;
  logic              r_halted;
  logic [RAM_AW-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_ram_wren;

  logic [2:0]        w_state_nxt;
  logic [ROM_AW-1:0] w_pc_nxt;
  logic [IW-1:0]     w_ir_nxt;
  logic [SP_W-1:0]   w_sp_nxt;
  logic [DATA_W-1:0] w_stack_nxt [STACK_DEPTH];
  logic [1:0]        w_trap_nxt;
  logic              w_halted_nxt;
  logic [RAM_AW-1:0] w_ram_addr_nxt;
  logic [DATA_W-1:0] w_ram_wdata_nxt;
  logic              w_ram_wren_nxt;

  logic [4:0]        w_opcode;
  logic [OPW-1:0]    w_operand;
  logic [4:0]        w_rom_opcode;
  logic [OPW-1:0]    w_rom_operand;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_alu;
  logic              w_taken;
  logic              w_empty;
  logic              w_full;
  logic              w_lt2;
  logic [DATA_W-1:0] w_push_val;
  logic [DATA_W-1:0] w_push_stk [STACK_DEPTH];
  logic [DATA_W-1:0] w_pop1_stk [STACK_DEPTH];
  logic [DATA_W-1:0] w_pop2_stk [STACK_DEPTH];
  logic [DATA_W-1:0] w_bin_stk  [STACK_DEPTH];

  assign w_opcode      = r_ir[IW-1 -: 5];
  assign w_operand     = r_ir[OPW-1:0];
  assign w_rom_opcode  = i_rom_q[IW-1 -: 5];
  assign w_rom_operand = i_rom_q[OPW-1:0];
  assign w_b           = r_stack[0];
  assign w_a           = r_stack[1];
  assign w_empty       = (r_sp == '0);
  assign w_full        = (r_sp == SP_FULL);
  assign w_lt2         = (r_sp < SP_TWO);

  // Entry 0 is the top; entries at or beyond sp are always held at zero so tos reads 0 when empty.
  always_comb begin : push_source
    w_push_val = DATA_W'(w_operand);
    if (r_state == S_MEM) begin
      w_push_val = i_ram_rdata;
    end else if (w_opcode == OP_DUP) begin
      w_push_val = w_b;
    end
  end

  always_comb begin : stack_shapes
    w_push_stk[0] = w_push_val;
    for (int i = 1; i < int'(STACK_DEPTH); i++) begin
      w_push_stk[i] = r_stack[i-1];
    end
    for (int i = 0; i < int'(STACK_DEPTH) - 1; i++) begin
      w_pop1_stk[i] = r_stack[i+1];
    end
    w_pop1_stk[STACK_DEPTH-1] = '0;
    for (int i = 0; i < int'(STACK_DEPTH) - 2; i++) begin
      w_pop2_stk[i] = r_stack[i+2];
    end
    w_pop2_stk[STACK_DEPTH-2] = '0;
    w_pop2_stk[STACK_DEPTH-1] = '0;
    w_bin_stk    = w_pop1_stk;
    w_bin_stk[0] = w_alu;
  end

  always_comb begin : alu
    w_alu   = '0;
    w_taken = 1'b0;
    case (w_opcode)
      OP_ADD:  w_alu = w_a + w_b;
      OP_SUB:  w_alu = w_a - w_b;
      OP_MUL:  w_alu = w_a * w_b;
      OP_AND:  w_alu = w_a & w_b;
      OP_OR:   w_alu = w_a | w_b;
      OP_XOR:  w_alu = w_a ^ w_b;
      OP_IFEQ: w_taken = (w_a == w_b);
      OP_IFGT: w_taken = (w_a > w_b);
      OP_IFLT: w_taken = (w_a < w_b);
      default: w_alu = '0;
    endcase
  end

  // Next-state and next-register values; traps leave stack, pc and RAM untouched.
  always_comb begin : fsm_next
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_ir_nxt        = r_ir;
    w_sp_nxt        = r_sp;
    w_stack_nxt     = r_stack;
    w_trap_nxt      = r_trap;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_wdata_nxt = r_ram_wdata;
    w_ram_wren_nxt  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        w_ir_nxt        = i_rom_q;
        w_pc_nxt        = r_pc + ROM_AW'(1);
        w_ram_addr_nxt  = RAM_AW'(w_rom_operand);
        w_ram_wdata_nxt = w_b;
        w_ram_wren_nxt  = (w_rom_opcode == OP_POP_M) && !w_empty;
        w_state_nxt     = S_EXEC;
      end
      S_EXEC: begin
        w_state_nxt = S_FETCH;
        case (w_opcode)
          OP_NOP: begin
          end
          OP_PUSH_M: begin
            if (w_full) begin
              w_state_nxt = S_TRAP;
              w_trap_nxt  = TRAP_OVF;
            end else begin
              w_state_nxt = S_MEM;
            end
          end
          OP_PUSH_I, OP_DUP: begin
            if ((w_opcode == OP_DUP) && w_empty) begin
              w_state_nxt = S_TRAP;
              w_trap_nxt  = TRAP_UNF;
            end else if (w_full) begin
              w_state_nxt = S_TRAP;
              w_trap_nxt  = TRAP_OVF;
            end else begin
              w_stack_nxt = w_push_stk;
              w_sp_nxt    = r_sp + SP_ONE;
            end
          end
          OP_POP_M: begin
            if (w_empty) begin
              w_state_nxt = S_TRAP;
              w_trap_nxt  = TRAP_UNF;
            end else begin
              w_stack_nxt = w_pop1_stk;
              w_sp_nxt    = r_sp - SP_ONE;
            end
          end
          OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: begin
            if (w_lt2) begin
              w_state_nxt = S_TRAP;
              w_trap_nxt  = TRAP_UNF;
            end else begin
              w_stack_nxt = w_bin_stk;
              w_sp_nxt    = r_sp - SP_ONE;
            end
          end
          OP_NOT: begin
            if (w_empty) begin
              w_state_nxt = S_TRAP;
              w_trap_nxt  = TRAP_UNF;
            end else begin
              w_stack_nxt[0] = ~w_b;
            end
          end
          OP_GOTO: begin
            w_pc_nxt = ROM_AW'(w_operand);
          end
          OP_IFEQ, OP_IFGT, OP_IFLT: begin
            if (w_lt2) begin
              w_state_nxt = S_TRAP;
              w_trap_nxt  = TRAP_UNF;
            end else begin
              w_stack_nxt = w_pop2_stk;
              w_sp_nxt    = r_sp - SP_TWO;
              if (w_taken) begin
                w_pc_nxt = ROM_AW'(w_operand);
              end
            end
          end
          OP_HALT: begin
            w_state_nxt = S_HALT;
          end
          default: begin
            w_state_nxt = S_TRAP;
            w_trap_nxt  = TRAP_ILL;
          end
        endcase
      end
      S_MEM: begin
        w_stack_nxt = w_push_stk;
        w_sp_nxt    = r_sp + SP_ONE;
        w_state_nxt = S_FETCH;
      end
      S_HALT, S_TRAP: begin
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
    w_halted_nxt = (w_state_nxt == S_HALT) || (w_state_nxt == S_TRAP);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin : state_reg
    if (!i_reset_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin : datapath_reg
    if (!i_reset_n) begin
      r_pc        <= '0;
      r_ir        <= '0;
      r_sp        <= '0;
      r_trap      <= '0;
      r_halted    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_wren  <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        r_stack[i] <= '0;
      end
    end else begin
      r_pc        <= w_pc_nxt;
      r_ir        <= w_ir_nxt;
      r_sp        <= w_sp_nxt;
      r_trap      <= w_trap_nxt;
      r_halted    <= w_halted_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_ram_wren  <= w_ram_wren_nxt;
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        r_stack[i] <= w_stack_nxt[i];
      end
    end
  end

  assign o_rom_addr  = r_pc;
  assign o_pc        = r_pc;
  assign o_sp        = r_sp;
  assign o_tos       = r_stack[0];
  assign o_trap      = r_trap;
  assign o_halted    = r_halted;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_ram_wren  = r_ram_wren;

endmodule

// File: tb/tb_stack_proc_core.sv
// Directed bench for stack_proc_core: default build plus an 8-bit, depth-4, 3-bit-ROM build.
module tb_stack_proc_core;

  localparam logic [4:0] NOP = 5'h00, PUSH_M = 5'h01, PUSH_I = 5'h02, DUP = 5'h03;
  localparam logic [4:0] POP_M = 5'h04, ADD = 5'h05, SUB = 5'h06, MUL = 5'h07;
  localparam logic [4:0] AND_ = 5'h08, OR_ = 5'h09, XOR_ = 5'h0A, NOT_ = 5'h0B;
  localparam logic [4:0] GOTO = 5'h0C, IFEQ = 5'h0D, IFGT = 5'h0E, IFLT = 5'h0F;
  localparam logic [4:0] HALT = 5'h1F;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Build A: default parameters
  logic [4:0]  rom_addr_a, ram_addr_a, pc_a;
  logic [9:0]  rom_q_a;
  logic [15:0] ram_wdata_a, ram_rdata_a, tos_a;
  logic        ram_wren_a, halted_a;
  logic [1:0]  trap_a;
  logic [3:0]  sp_a;
  logic [9:0]  rom_a      [32];
  logic [15:0] ram_a      [32];
  logic [15:0] ram_init_a [32];

  stack_proc_core u_dut_a (
    .i_clock(clk), .i_reset_n(rst_n),
    .o_rom_addr(rom_addr_a), .i_rom_q(rom_q_a),
    .o_ram_addr(ram_addr_a), .o_ram_wdata(ram_wdata_a), .o_ram_wren(ram_wren_a),
    .i_ram_rdata(ram_rdata_a), .o_halted(halted_a), .o_trap(trap_a),
    .o_pc(pc_a), .o_sp(sp_a), .o_tos(tos_a)
  );

  always @(posedge clk) begin
    rom_q_a <= rom_a[rom_addr_a];
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) ram_a[i] <= ram_init_a[i];
    end else if (ram_wren_a) begin
      ram_a[ram_addr_a] <= ram_wdata_a;
    end
    ram_rdata_a <= ram_a[ram_addr_a];
  end

  // Build B: DATA_W=8, RAM_AW=3, ROM_AW=3, STACK_DEPTH=4
  logic [2:0] rom_addr_b, ram_addr_b, pc_b, sp_b;
  logic [7:0] rom_q_b, ram_wdata_b, ram_rdata_b, tos_b;
  logic       ram_wren_b, halted_b;
  logic [1:0] trap_b;
  logic [7:0] rom_b [8];
  logic [7:0] ram_b [8];

  stack_proc_core #(.DATA_W(8), .RAM_AW(3), .ROM_AW(3), .STACK_DEPTH(4)) u_dut_b (
    .i_clock(clk), .i_reset_n(rst_n),
    .o_rom_addr(rom_addr_b), .i_rom_q(rom_q_b),
    .o_ram_addr(ram_addr_b), .o_ram_wdata(ram_wdata_b), .o_ram_wren(ram_wren_b),
    .i_ram_rdata(ram_rdata_b), .o_halted(halted_b), .o_trap(trap_b),
    .o_pc(pc_b), .o_sp(sp_b), .o_tos(tos_b)
  );

  always @(posedge clk) begin
    rom_q_b <= rom_b[rom_addr_b];
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) ram_b[i] <= 8'h00;
    end else if (ram_wren_b) begin
      ram_b[ram_addr_b] <= ram_wdata_b;
    end
    ram_rdata_b <= ram_b[ram_addr_b];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ia(input logic [4:0] op, input int unsigned opd);
    return {op, 5'(opd)};
  endfunction

  function automatic logic [7:0] ib(input logic [4:0] op, input int unsigned opd);
    return {op, 3'(opd)};
  endfunction

  task automatic clear_all();
    for (int i = 0; i < 32; i++) begin
      rom_a[i]      = ia(HALT, 0);
      ram_init_a[i] = 16'h0000;
    end
    for (int i = 0; i < 8; i++) rom_b[i] = ib(HALT, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic restart();
    rst_n = 1'b0;
    release_reset();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_halt_a(input int budget, output int cyc);
    cyc = 0;
    while (!halted_a && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("halt_reached_a", 32'(halted_a), 32'd1);
  endtask

  task automatic wait_halt_b(input int budget, output int cyc);
    cyc = 0;
    while (!halted_b && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("halt_reached_b", 32'(halted_b), 32'd1);
  endtask

  int cyc;

  initial begin
    // Add and store: RAM[2]=8, halts after exactly 15 cycles
    clear_all();
    rom_a[0] = ia(PUSH_I, 3); rom_a[1] = ia(PUSH_I, 5); rom_a[2] = ia(ADD, 0);
    rom_a[3] = ia(POP_M, 2);  rom_a[4] = ia(HALT, 0);
    release_reset();
    check("rst_pc", 32'(pc_a), 32'd0);
    check("rst_sp", 32'(sp_a), 32'd0);
    check("rst_halted", 32'(halted_a), 32'd0);
    run(9);
    check("add_tos", 32'(tos_a), 32'd8);
    check("add_sp", 32'(sp_a), 32'd1);
    run(2);
    check("popm_wren", 32'(ram_wren_a), 32'd1);
    check("popm_addr", 32'(ram_addr_a), 32'd2);
    check("popm_wdata", 32'(ram_wdata_a), 32'd8);
    run(1);
    check("popm_wren_drop", 32'(ram_wren_a), 32'd0);
    run(2);
    check("halted_at_14", 32'(halted_a), 32'd0);
    run(1);
    check("halted_at_15", 32'(halted_a), 32'd1);
    check("prog1_sp", 32'(sp_a), 32'd0);
    check("prog1_pc", 32'(pc_a), 32'd5);
    check("prog1_trap", 32'(trap_a), 32'd0);
    check("prog1_ram2", 32'(ram_a[2]), 32'd8);

    // SUB wraps: 2-7
    clear_all();
    rom_a[0] = ia(PUSH_I, 2); rom_a[1] = ia(PUSH_I, 7); rom_a[2] = ia(SUB, 0);
    restart();
    wait_halt_a(100, cyc);
    check("sub_cycles", 32'(cyc), 32'd12);
    check("sub_tos", 32'(tos_a), 32'hFFFB);
    check("sub_sp", 32'(sp_a), 32'd1);

    // MUL 0x0100*0x0100 via PUSH_M/DUP; PUSH_M takes 4 cycles
    clear_all();
    ram_init_a[0] = 16'h0100;
    rom_a[0] = ia(PUSH_M, 0); rom_a[1] = ia(DUP, 0); rom_a[2] = ia(MUL, 0);
    restart();
    wait_halt_a(100, cyc);
    check("mul_cycles", 32'(cyc), 32'd13);
    check("mul_tos", 32'(tos_a), 32'h0000);
    check("mul_sp", 32'(sp_a), 32'd1);

    // Load and add
    clear_all();
    ram_init_a[3] = 16'h1234;
    rom_a[0] = ia(PUSH_M, 3); rom_a[1] = ia(PUSH_I, 1); rom_a[2] = ia(ADD, 0);
    restart();
    wait_halt_a(100, cyc);
    check("load_add_tos", 32'(tos_a), 32'h1235);

    // Logic chain: ~(((12&10)|5)^3) = 0xFFF1
    clear_all();
    rom_a[0] = ia(PUSH_I, 12); rom_a[1] = ia(PUSH_I, 10); rom_a[2] = ia(AND_, 0);
    rom_a[3] = ia(PUSH_I, 5);  rom_a[4] = ia(OR_, 0);     rom_a[5] = ia(PUSH_I, 3);
    rom_a[6] = ia(XOR_, 0);    rom_a[7] = ia(NOT_, 0);
    restart();
    wait_halt_a(100, cyc);
    check("logic_tos", 32'(tos_a), 32'hFFF1);
    check("logic_sp", 32'(sp_a), 32'd1);
    check("logic_trap", 32'(trap_a), 32'd0);

    // Overflow on ninth push
    clear_all();
    for (int i = 0; i < 9; i++) rom_a[i] = ia(PUSH_I, i + 1);
    restart();
    wait_halt_a(100, cyc);
    check("ovf_cycles", 32'(cyc), 32'd27);
    check("ovf_trap", 32'(trap_a), 32'd1);
    check("ovf_sp", 32'(sp_a), 32'd8);
    check("ovf_tos", 32'(tos_a), 32'd8);
    check("ovf_pc", 32'(pc_a), 32'd9);

    // Underflow: ADD on empty
    clear_all();
    rom_a[0] = ia(ADD, 0);
    restart();
    wait_halt_a(20, cyc);
    check("unf_add_cycles", 32'(cyc), 32'd3);
    check("unf_add_trap", 32'(trap_a), 32'd2);
    check("unf_add_sp", 32'(sp_a), 32'd0);

    // Underflow: POP_M on empty must not write RAM
    clear_all();
    ram_init_a[4] = 16'hAAAA;
    rom_a[0] = ia(POP_M, 4);
    restart();
    wait_halt_a(20, cyc);
    check("unf_popm_trap", 32'(trap_a), 32'd2);
    check("unf_popm_ram", 32'(ram_a[4]), 32'hAAAA);

    // IFEQ taken
    clear_all();
    rom_a[0] = ia(PUSH_I, 4); rom_a[1] = ia(PUSH_I, 4); rom_a[2] = ia(IFEQ, 9);
    restart();
    run(9);
    check("ifeq_pc", 32'(pc_a), 32'd9);
    check("ifeq_sp", 32'(sp_a), 32'd0);
    wait_halt_a(20, cyc);
    check("ifeq_halt_pc", 32'(pc_a), 32'd10);

    // IFGT not taken (3>4 false), IFLT taken (3<4)
    clear_all();
    rom_a[0] = ia(PUSH_I, 3); rom_a[1] = ia(PUSH_I, 4); rom_a[2] = ia(IFGT, 9);
    restart();
    run(9);
    check("ifgt_pc", 32'(pc_a), 32'd3);
    check("ifgt_sp", 32'(sp_a), 32'd0);
    clear_all();
    rom_a[0] = ia(PUSH_I, 3); rom_a[1] = ia(PUSH_I, 4); rom_a[2] = ia(IFLT, 9);
    restart();
    run(9);
    check("iflt_pc", 32'(pc_a), 32'd9);

    // GOTO to own address loops without trapping
    clear_all();
    rom_a[0] = ia(PUSH_I, 1); rom_a[1] = ia(GOTO, 1);
    restart();
    run(30);
    check("goto_pc", 32'(pc_a), 32'd1);
    check("goto_halted", 32'(halted_a), 32'd0);
    check("goto_sp", 32'(sp_a), 32'd1);

    // Illegal opcode
    clear_all();
    rom_a[0] = ia(5'h12, 0);
    restart();
    wait_halt_a(20, cyc);
    check("ill_trap", 32'(trap_a), 32'd3);
    check("ill_cycles", 32'(cyc), 32'd3);

    // Reset asserted during POP_M EXEC clears outputs immediately
    clear_all();
    rom_a[0] = ia(PUSH_I, 5); rom_a[1] = ia(POP_M, 6);
    restart();
    run(5);
    check("mid_popm_wren", 32'(ram_wren_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_wren", 32'(ram_wren_a), 32'd0);
    check("arst_pc", 32'(pc_a), 32'd0);
    check("arst_rom_addr", 32'(rom_addr_a), 32'd0);
    check("arst_sp", 32'(sp_a), 32'd0);
    check("arst_tos", 32'(tos_a), 32'd0);
    check("arst_wdata", 32'(ram_wdata_a), 32'd0);

    // Reset asserted during PUSH_M MEM, then restart from pc 0
    clear_all();
    ram_init_a[3] = 16'h1234;
    rom_a[0] = ia(PUSH_M, 3);
    release_reset();
    run(3);
    check("mid_pushm_addr", 32'(ram_addr_a), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst2_addr", 32'(ram_addr_a), 32'd0);
    check("arst2_pc", 32'(pc_a), 32'd0);
    check("arst2_trap", 32'(trap_a), 32'd0);
    release_reset();
    run(2);
    check("restart_pc", 32'(pc_a), 32'd1);
    wait_halt_a(20, cyc);
    check("restart_tos", 32'(tos_a), 32'h1234);
    check("restart_sp", 32'(sp_a), 32'd1);

    // Build B: 8-bit SUB wrap
    clear_all();
    rom_b[0] = ib(PUSH_I, 2); rom_b[1] = ib(PUSH_I, 7); rom_b[2] = ib(SUB, 0);
    restart();
    wait_halt_b(100, cyc);
    check("b_sub_cycles", 32'(cyc), 32'd12);
    check("b_sub_tos", 32'(tos_b), 32'hFB);
    check("b_sub_sp", 32'(sp_b), 32'd1);

    // Build B: overflow on fifth push with depth 4
    clear_all();
    for (int i = 0; i < 5; i++) rom_b[i] = ib(PUSH_I, i + 1);
    restart();
    wait_halt_b(100, cyc);
    check("b_ovf_trap", 32'(trap_b), 32'd1);
    check("b_ovf_sp", 32'(sp_b), 32'd4);
    check("b_ovf_tos", 32'(tos_b), 32'd4);

    // Build B: pc wraps 7 -> 0 through NOPs
    clear_all();
    for (int i = 0; i < 8; i++) rom_b[i] = ib(NOP, 0);
    restart();
    run(21);
    check("b_pc_7", 32'(pc_b), 32'd7);
    run(3);
    check("b_pc_wrap", 32'(pc_b), 32'd0);
    check("b_wrap_halted", 32'(halted_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
